// File: rtl/lane_traffic_monitor_pkg.sv
// Shared types for the lane traffic monitor: emergency FSM encoding, lane
// index constants and the round-robin pick helper.
package lane_traffic_monitor_pkg;

    localparam int NUM_LANES = 8;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'b00,
        ST_GRANT   = 2'b01,
        ST_RELEASE = 2'b10
    } emg_state_e;

    localparam int LANE_W1 = 0;
    localparam int LANE_W2 = 1;
    localparam int LANE_N1 = 2;
    localparam int LANE_N2 = 3;
    localparam int LANE_E1 = 4;
    localparam int LANE_E2 = 5;
    localparam int LANE_S1 = 6;
    localparam int LANE_S2 = 7;

    // First requesting lane at index >= ptr, wrapping past S2 back to W1.
    function automatic logic [2:0] rr_pick(input logic [7:0] req, input logic [2:0] ptr);
        logic [2:0] idx;
        logic       found;
        rr_pick = ptr;
        found   = 1'b0;
        for (int off = 0; off < NUM_LANES; off++) begin
            idx = ptr + 3'(off);
            if (!found && req[idx]) begin
                rr_pick = idx;
                found   = 1'b1;
            end
        end
    endfunction

endpackage

// File: rtl/lane_traffic_monitor_lane_queue_counter.sv
// One lane's vehicle queue: saturating arrival counter drained by one vehicle
// every DEPART_TICKS cycles of green.
module lane_queue_counter #(
    parameter int CNT_W        = 8,
    parameter int DEPART_TICKS = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_inc,
    input  logic             i_green,
    output logic [CNT_W-1:0] o_count
);

    localparam int TW = (DEPART_TICKS > 1) ? $clog2(DEPART_TICKS) : 1;

    logic [TW-1:0]    r_timer;
    logic [CNT_W-1:0] r_count;
    logic             w_tick_end;
    logic             w_dec;

    assign w_tick_end = (r_timer == TW'(DEPART_TICKS - 1));
    assign w_dec      = i_green & w_tick_end & (r_count != '0);

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_timer <= '0;
            r_count <= '0;
        end else begin
            // Going red throws away any partial departure interval.
            if (i_green) begin
                r_timer <= w_tick_end ? '0 : r_timer + 1'b1;
            end else begin
                r_timer <= '0;
            end

            case ({i_inc, w_dec})
                2'b10: begin
                    if (r_count != '1) begin
                        r_count <= r_count + 1'b1;
                    end
                end
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    assign o_count = r_count;

endmodule

// File: rtl/lane_traffic_monitor.sv
// Per-lane queue counts plus round-robin emergency request arbitration.
// Define LANE_MONITOR_EMG_TIMEOUT_EN to release a grant after EMG_HOLD_MAX cycles.
module lane_traffic_monitor
    import lane_traffic_monitor_pkg::*;
#(
    parameter int LANES        = 8,
    parameter int CNT_W        = 8,
    parameter int DEPART_TICKS = 4,
    parameter int EMG_HOLD_MAX = 64
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [LANES-1:0]       arrive,
    input  logic [LANES-1:0]       emgArrive,
    input  logic [LANES-1:0]       lightOut,
    input  logic                   emgClear,
    output logic [LANES*CNT_W-1:0] laneCount,
    output logic                   emgSignal,
    output logic [LANES-1:0]       emgLane,
    output logic [LANES-1:0]       emgPending,
    output logic [1:0]             dbgState
);

    if (LANES != NUM_LANES || DEPART_TICKS < 1 || EMG_HOLD_MAX < 1) begin : g_bad_cfg
        $error("lane_traffic_monitor: unsupported parameter set");
    end

    // Queue counters, one per lane
    for (genvar gi = 0; gi < LANES; gi++) begin : g_lane
        lane_queue_counter #(
            .CNT_W       (CNT_W),
            .DEPART_TICKS(DEPART_TICKS)
        ) u_cnt (
            .clk    (clk),
            .rst    (rst),
            .i_inc  (arrive[gi] | emgArrive[gi]),
            .i_green(lightOut[gi]),
            .o_count(laneCount[gi*CNT_W +: CNT_W])
        );
    end

    emg_state_e       r_state;
    logic             r_sig;
    logic [LANES-1:0] r_lane;
    logic [LANES-1:0] r_pending;
    logic [2:0]       r_ptr;

    logic [2:0]       w_pick;
    logic [LANES-1:0] w_pick_oh;
    logic [LANES-1:0] w_grant_clr;
    logic             w_release;

    assign w_pick      = rr_pick(r_pending, r_ptr);
    assign w_pick_oh   = LANES'(1) << w_pick;
    assign w_grant_clr = (r_state == ST_IDLE && r_pending != '0) ? w_pick_oh : '0;

`ifdef LANE_MONITOR_EMG_TIMEOUT_EN
    localparam int HW = (EMG_HOLD_MAX > 1) ? $clog2(EMG_HOLD_MAX) : 1;

    logic [HW-1:0] r_hold;
    logic          w_hold_end;

    assign w_hold_end = (r_hold == HW'(EMG_HOLD_MAX - 1));
    assign w_release  = emgClear | w_hold_end;

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_hold <= '0;
        end else if (r_state != ST_GRANT) begin
            r_hold <= '0;
        end else if (!w_hold_end) begin
            r_hold <= r_hold + 1'b1;
        end
    end
`else
    assign w_release = emgClear;
`endif

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state   <= ST_IDLE;
            r_sig     <= 1'b0;
            r_lane    <= '0;
            r_pending <= '0;
            r_ptr     <= 3'(LANE_W1);
        end else begin
            // A fresh request on the granted lane re-arms it for a later turn.
            r_pending <= (r_pending & ~w_grant_clr) | emgArrive;
            case (r_state)
                ST_IDLE: begin
                    if (r_pending != '0) begin
                        r_state <= ST_GRANT;
                        r_sig   <= 1'b1;
                        r_lane  <= w_pick_oh;
                        r_ptr   <= (w_pick == 3'(LANE_S2)) ? 3'(LANE_W1) : w_pick + 3'd1;
                    end
                end
                ST_GRANT: begin
                    if (w_release) begin
                        r_state <= ST_RELEASE;
                        r_sig   <= 1'b0;
                        r_lane  <= '0;
                    end
                end
                ST_RELEASE: begin
                    r_state <= ST_IDLE;
                end
                default: begin
                    r_state <= ST_IDLE;
                    r_sig   <= 1'b0;
                    r_lane  <= '0;
                end
            endcase
        end
    end

    assign emgSignal  = r_sig;
    assign emgLane    = r_lane;
    assign emgPending = r_pending;
    assign dbgState   = r_state;

endmodule
